int_ctrl: RTL and testbench

Interrupt and exception arbiter directly upstream of the CP0 register block. It edge-detects and latches external interrupt requests and masks them against the live Status word. It waits for a pipeline-safe instruction boundary and then issues the one-cycle `inta` pulse plus the `cause` word that CP0 captures. It tracks handler nesting depth using `eret`.

---
 rtl/int_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_int_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt/exception arbiter feeding the CP0 register block.
// Edge-detects external requests into sticky pending bits and masks them
// against the live Status word. It waits for an instruction boundary,
// then issues a one-cycle acknowledge together with the cause word.
// It also tracks handler nesting depth, which eret unwinds.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | nothing eligible, or returning from an acknowledge
//  S_WAIT | an eligible irq exists, waiting for a safe boundary
//  S_ACK  | inta/flush high for this cycle; cause holds the new word

module int_ctrl #(
    parameter int          NIRQ    = 3,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            exc,
    input  logic [4:0]      exc_code,
    input  logic [31:0]     sta,
    input  logic            eret,
    input  logic            safe,
    output logic            inta,
    output logic [31:0]     cause,
    output logic            flush,
    output logic [31:0]     vec,
    output logic [NIRQ-1:0] pending,
    output logic [2:0]      depth
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [2:0] DEPTH_MAX = 3'd7;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] irq_q, irq_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] ack_mask_q, ack_mask_d;
    logic [31:0]     cause_q, cause_d;
    logic [2:0]      depth_q, depth_d;
    logic            inta_q, inta_d;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] elig;
    logic [NIRQ-1:0] win_mask;
    logic [NIRQ-1:0] clr_mask;
    logic            any_elig;
    logic            irq_allowed;
    logic            in_ack;
    logic [31:0]     exc_cause;
    logic [31:0]     irq_cause;

    // Status bits above the per-line enables carry nothing for this block.
    logic            unused_sta;
    assign unused_sta = ^sta[31:NIRQ+1];

    // Rising-edge detection of the request lines.
    always_comb begin
        irq_d = irq;
        rise  = irq & ~irq_q;
    end

    // Eligibility: enabled pending lines, global IE, and room to nest.
    always_comb begin
        irq_allowed = sta[0] && (depth_q != DEPTH_MAX);
        elig        = pending_q & sta[NIRQ:1] & {NIRQ{irq_allowed}};
        any_elig    = |elig;
    end

    // Highest-index eligible line wins, expressed as a one-hot mask.
    always_comb begin
        win_mask = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (elig[i]) begin
                win_mask    = '0;
                win_mask[i] = 1'b1;
            end
        end
    end

    // Candidate cause words; both snapshot the pending bits at ACK entry.
    always_comb begin
        exc_cause              = '0;
        exc_cause[6:2]         = exc_code;
        exc_cause[10 +: NIRQ]  = pending_q;
        irq_cause              = '0;
        irq_cause[31]          = 1'b1;
        irq_cause[10 +: NIRQ]  = pending_q;
    end

    // Next-state logic; exceptions preempt interrupts in IDLE and WAIT.
    always_comb begin
        state_d    = state_q;
        ack_mask_d = ack_mask_q;
        cause_d    = cause_q;
        case (state_q)
            S_IDLE: begin
                if (exc) begin
                    state_d    = S_ACK;
                    ack_mask_d = '0;
                    cause_d    = exc_cause;
                end else if (any_elig) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (exc) begin
                    state_d    = S_ACK;
                    ack_mask_d = '0;
                    cause_d    = exc_cause;
                end else if (any_elig && safe) begin
                    state_d    = S_ACK;
                    ack_mask_d = win_mask;
                    cause_d    = irq_cause;
                end else if (!any_elig) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                // An exc arriving here is dropped: the pipeline is flushing.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        inta_d = (state_d == S_ACK);
    end

    // Pending bits: acknowledged line cleared on leaving ACK, new edge wins.
    always_comb begin
        in_ack    = (state_q == S_ACK);
        clr_mask  = in_ack ? ack_mask_q : '0;
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    // Nesting depth, saturating at both ends; ack plus eret cancel out.
    always_comb begin
        depth_d = depth_q;
        case ({in_ack, eret})
            2'b10: if (depth_q != DEPTH_MAX) depth_d = depth_q + 3'd1;
            2'b01: if (depth_q != 3'd0)      depth_d = depth_q - 3'd1;
            default: depth_d = depth_q;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            irq_q      <= '0;
            pending_q  <= '0;
            ack_mask_q <= '0;
            cause_q    <= '0;
            depth_q    <= '0;
            inta_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            pending_q  <= pending_d;
            ack_mask_q <= ack_mask_d;
            cause_q    <= cause_d;
            depth_q    <= depth_d;
            inta_q     <= inta_d;
        end
    end

    // Outputs come straight from flops so CP0 sees clean full-period levels.
    always_comb begin
        inta    = inta_q;
        flush   = inta_q;
        cause   = cause_q;
        vec     = HANDLER;
        pending = pending_q;
        depth   = depth_q;
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the arbitration rules.
module tb_int_ctrl;

    localparam int          NIRQ = 3;
    localparam logic [31:0] HVEC = 32'h0000_4180;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            exc;
    logic [4:0]      exc_code;
    logic [31:0]     sta;
    logic            eret;
    logic            safe;
    logic            inta;
    logic [31:0]     cause;
    logic            flush;
    logic [31:0]     vec;
    logic [NIRQ-1:0] pending;
    logic [2:0]      depth;

    int n_vec = 0;
    int n_err = 0;

    int_ctrl #(.NIRQ(NIRQ), .HANDLER(HVEC)) dut (
        .clk(clk), .rst(rst), .irq(irq), .exc(exc), .exc_code(exc_code),
        .sta(sta), .eret(eret), .safe(safe), .inta(inta), .cause(cause),
        .flush(flush), .vec(vec), .pending(pending), .depth(depth)
    );

    always #5 clk = ~clk;

    // Model state: pending lines, last irq sample, depth, and where we are
    // in the request -> boundary -> acknowledge sequence.
    logic [NIRQ-1:0] m_pend, m_prev;
    int              m_depth;
    bit              m_wait, m_ack;
    int              m_line;
    logic [31:0]     m_cause;

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_depth = 0;
        m_wait = 0; m_ack = 0; m_line = -1; m_cause = '0;
    endtask

    // One clock edge of the model, using the inputs the DUT samples.
    task automatic model_step();
        int win;
        logic [NIRQ-1:0] nxt;
        logic [31:0] c;
        if (rst) begin
            model_reset();
            return;
        end
        win = -1;
        for (int i = 0; i < NIRQ; i++)
            if (m_pend[i] && sta[i+1] && sta[0] && m_depth < 7) win = i;
        nxt = m_pend;
        if (m_ack) begin
            if (m_line >= 0) nxt[m_line] = 1'b0;
            if (!eret && m_depth < 7) m_depth = m_depth + 1;
            m_ack = 0; m_wait = 0;
        end else begin
            if (eret && m_depth > 0) m_depth = m_depth - 1;
            c = '0;
            c[10 +: NIRQ] = m_pend;
            if (exc) begin
                c[6:2] = exc_code;
                m_cause = c; m_ack = 1; m_wait = 0; m_line = -1;
            end else if (m_wait && win >= 0 && safe) begin
                c[31] = 1'b1;
                m_cause = c; m_ack = 1; m_wait = 0; m_line = win;
            end else begin
                m_wait = (win >= 0);
            end
        end
        for (int i = 0; i < NIRQ; i++)
            if (irq[i] && !m_prev[i]) nxt[i] = 1'b1;
        m_pend = nxt;
        m_prev = irq;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; irq = '0; exc = 1'b0; exc_code = '0;
        sta = '0; eret = 1'b0; safe = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = '0; exc = 1'b0; exc_code = '0;
        sta = 32'hFFFF_FFFF; eret = 1'b0; safe = 1'b1;
        step(); step();
        n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL reset_inta got=%0b exp=0", inta); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%0b exp=0", flush); end
        n_vec++; if (cause !== 32'h0) begin n_err++; $display("FAIL reset_cause got=%h exp=0", cause); end
        n_vec++; if (pending !== 3'b000) begin n_err++; $display("FAIL reset_pending got=%b exp=000", pending); end
        n_vec++; if (depth !== 3'd0) begin n_err++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        n_vec++; if (vec !== 32'h0000_4180) begin n_err++; $display("FAIL reset_vec got=%h exp=00004180", vec); end
        rst = 1'b0;
        step(); step();
        n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL reset_idle_inta got=%0b exp=0", inta); end
    endtask

    task automatic test_single_irq();
        do_reset();
        sta = 32'h5; safe = 1'b1; irq = 3'b010;
        step();
        n_vec++; if (pending !== 3'b010) begin n_err++; $display("FAIL single_pending got=%b exp=010", pending); end
        n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL single_early1 got=%0b exp=0", inta); end
        step();
        n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL single_early2 got=%0b exp=0", inta); end
        step();
        n_vec++; if (inta !== 1'b1 || flush !== 1'b1) begin n_err++; $display("FAIL single_inta got=%0b/%0b exp=1/1", inta, flush); end
        n_vec++; if (cause !== 32'h8000_0800) begin n_err++; $display("FAIL single_cause got=%h exp=80000800", cause); end
        step();
        n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL single_pulse_len got=%0b exp=0", inta); end
        n_vec++; if (depth !== 3'd1) begin n_err++; $display("FAIL single_depth got=%0d exp=1", depth); end
        n_vec++; if (pending !== 3'b000) begin n_err++; $display("FAIL single_clear got=%b exp=000", pending); end
        n_vec++; if (cause !== 32'h8000_0800) begin n_err++; $display("FAIL single_cause_hold got=%h exp=80000800", cause); end
    endtask

    task automatic test_priority();
        do_reset();
        sta = 32'hF; safe = 1'b1; irq = 3'b101;
        step(); step(); step();
        n_vec++; if (inta !== 1'b1) begin n_err++; $display("FAIL prio_first_inta got=%0b exp=1", inta); end
        n_vec++; if (cause !== 32'h8000_1400) begin n_err++; $display("FAIL prio_first_cause got=%h exp=80001400", cause); end
        sta = 32'h0; irq = '0;
        step();
        n_vec++; if (pending !== 3'b001) begin n_err++; $display("FAIL prio_left got=%b exp=001", pending); end
        eret = 1'b1; sta = 32'hF;
        step();
        eret = 1'b0;
        n_vec++; if (depth !== 3'd0) begin n_err++; $display("FAIL prio_eret got=%0d exp=0", depth); end
        step();
        n_vec++; if (inta !== 1'b1) begin n_err++; $display("FAIL prio_second_inta got=%0b exp=1", inta); end
        n_vec++; if (cause !== 32'h8000_0400) begin n_err++; $display("FAIL prio_second_cause got=%h exp=80000400", cause); end
    endtask

    task automatic test_masked_wait();
        do_reset();
        sta = 32'h5; safe = 1'b0; irq = 3'b010;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL masked_unsafe cyc=%0d got=%0b exp=0", i, inta); end
        end
        sta = 32'h0;
        step();
        safe = 1'b1;
        step(); step();
        n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL masked_inta got=%0b exp=0", inta); end
        n_vec++; if (pending !== 3'b010) begin n_err++; $display("FAIL masked_pending got=%b exp=010", pending); end
        // Back in IDLE, re-enabling costs a WAIT cycle before the ack.
        sta = 32'h5;
        step();
        n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL masked_reenter got=%0b exp=0", inta); end
        step();
        n_vec++; if (inta !== 1'b1) begin n_err++; $display("FAIL masked_ack got=%0b exp=1", inta); end
    endtask

    task automatic test_exc_in_wait();
        do_reset();
        sta = 32'h5; safe = 1'b0; irq = 3'b010;
        step(); step();
        exc = 1'b1; exc_code = 5'd12;
        step();
        exc = 1'b0;
        n_vec++; if (inta !== 1'b1) begin n_err++; $display("FAIL exc_inta got=%0b exp=1", inta); end
        n_vec++; if (cause !== 32'h0000_0830) begin n_err++; $display("FAIL exc_cause got=%h exp=00000830", cause); end
        step();
        n_vec++; if (pending !== 3'b010) begin n_err++; $display("FAIL exc_pending got=%b exp=010", pending); end
        n_vec++; if (depth !== 3'd1) begin n_err++; $display("FAIL exc_depth got=%0d exp=1", depth); end
    endtask

    task automatic test_nesting();
        do_reset();
        sta = 32'h5; safe = 1'b1;
        for (int k = 0; k < 7; k++) begin
            irq = 3'b010;
            step(); step(); step();
            n_vec++; if (inta !== 1'b1) begin n_err++; $display("FAIL nest_ack k=%0d got=%0b exp=1", k, inta); end
            irq = '0;
            step();
            n_vec++; if (depth !== 3'(k + 1)) begin n_err++; $display("FAIL nest_depth k=%0d got=%0d exp=%0d", k, depth, k + 1); end
        end
        irq = 3'b010;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL nest_full cyc=%0d got=%0b exp=0", i, inta); end
        end
        exc = 1'b1; exc_code = 5'd3;
        step();
        exc = 1'b0;
        n_vec++; if (inta !== 1'b1 || cause !== 32'h0000_080C) begin n_err++; $display("FAIL nest_exc got=%0b/%h exp=1/0000080c", inta, cause); end
        step();
        n_vec++; if (depth !== 3'd7) begin n_err++; $display("FAIL nest_sat got=%0d exp=7", depth); end
        sta = 32'h0; eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++; if (depth !== 3'd6) begin n_err++; $display("FAIL nest_eret got=%0d exp=6", depth); end
        exc = 1'b1;
        step();
        exc = 1'b0; eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++; if (depth !== 3'd6) begin n_err++; $display("FAIL nest_ack_eret got=%0d exp=6", depth); end
    endtask

    task automatic test_rst_in_wait();
        do_reset();
        sta = 32'h5; safe = 1'b0; irq = 3'b010;
        step(); step();
        rst = 1'b1; irq = '0;
        step();
        n_vec++; if (inta !== 1'b0 || flush !== 1'b0 || cause !== 32'h0 || pending !== '0 || depth !== 3'd0) begin
            n_err++; $display("FAIL rst_wait_outputs got=%0b/%0b/%h/%b/%0d exp=0", inta, flush, cause, pending, depth);
        end
        rst = 1'b0; safe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (inta !== 1'b0) begin n_err++; $display("FAIL rst_wait_noack cyc=%0d got=%0b exp=0", i, inta); end
        end
        // A line held high through reset counts as a rising edge on release.
        rst = 1'b1; irq = 3'b010;
        step();
        rst = 1'b0;
        step();
        n_vec++; if (pending !== 3'b010) begin n_err++; $display("FAIL rst_high_line got=%b exp=010", pending); end
        step(); step();
        n_vec++; if (inta !== 1'b1) begin n_err++; $display("FAIL rst_high_ack got=%0b exp=1", inta); end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq = irq ^ (3'b001 << $urandom_range(0, NIRQ - 1));
            exc      = ($urandom_range(0, 11) == 0);
            exc_code = 5'($urandom_range(1, 31));
            eret     = ($urandom_range(0, 5) == 0);
            safe     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                sta    = $urandom;
                sta[0] = ($urandom_range(0, 3) != 0);
            end
            rst      = ($urandom_range(0, 149) == 0);
            @(posedge clk);
            model_step();
            #1;
            n_vec++; if (inta !== m_ack) begin n_err++; $display("FAIL rnd_inta n=%0d got=%0b exp=%0b", n, inta, m_ack); end
            n_vec++; if (flush !== m_ack) begin n_err++; $display("FAIL rnd_flush n=%0d got=%0b exp=%0b", n, flush, m_ack); end
            n_vec++; if (cause !== m_cause) begin n_err++; $display("FAIL rnd_cause n=%0d got=%h exp=%h", n, cause, m_cause); end
            n_vec++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pending n=%0d got=%b exp=%b", n, pending, m_pend); end
            n_vec++; if (depth !== 3'(m_depth)) begin n_err++; $display("FAIL rnd_depth n=%0d got=%0d exp=%0d", n, depth, m_depth); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_irq();
        test_priority();
        test_masked_wait();
        test_exc_in_wait();
        test_nesting();
        test_rst_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
